// File: rtl/box_reset_pkg.sv
// Shared types and the box offset table for the box reset engine.
package box_reset_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAW,
        DONE
    } state_e;

    typedef struct packed {
        logic [7:0] dx;
        logic [6:0] dy;
    } box_off_t;

    localparam logic [2:0] WHITE = 3'b111;
    localparam int MAX_BOXES = 8;

    // Offsets of each box relative to its lane's left column, in draw order.
    localparam box_off_t BOX_OFFSET [MAX_BOXES] = '{
        '{dx: 8'd5, dy: 7'd7},
        '{dx: 8'd0, dy: 7'd19},
        '{dx: 8'd0, dy: 7'd31},
        '{dx: 8'd5, dy: 7'd40},
        '{dx: 8'd5, dy: 7'd46},
        '{dx: 8'd5, dy: 7'd64},
        '{dx: 8'd0, dy: 7'd82},
        '{dx: 8'd0, dy: 7'd97}
    };

endpackage

// File: rtl/box_reset_engine_raster.sv
// Column/row raster counter walking one BOX_W x BOX_H rectangle.
module box_raster_counter #(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4,
    parameter int CW = (BOX_W > 1) ? $clog2(BOX_W) : 1,
    parameter int RW = (BOX_H > 1) ? $clog2(BOX_H) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cx_o,
    output logic [RW-1:0] cy_o,
    output logic          last_o
);

    logic [CW-1:0] cx_q;
    logic [RW-1:0] cy_q;
    logic          cx_end;
    logic          cy_end;

    assign cx_end = (cx_q == CW'(BOX_W - 1));
    assign cy_end = (cy_q == RW'(BOX_H - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_q <= '0;
            cy_q <= '0;
        end else if (clr_i) begin
            cx_q <= '0;
            cy_q <= '0;
        end else if (en_i) begin
            if (cx_end) begin
                cx_q <= '0;
                cy_q <= cy_end ? '0 : cy_q + 1'b1;
            end else begin
                cx_q <= cx_q + 1'b1;
            end
        end
    end

    assign cx_o   = cx_q;
    assign cy_o   = cy_q;
    assign last_o = cx_end && cy_end;

endmodule

// File: rtl/box_reset_engine.sv
// Repaints every box of the selected lanes as a filled rectangle, one pixel per cycle.
// Define BOX_RESET_MASK_EN to honour player_mask; otherwise every lane is repainted.
module box_reset_engine
    import box_reset_pkg::*;
#(
    parameter int         NUM_PLAYERS      = 2,
    parameter int         BOXES_PER_PLAYER = 8,
    parameter int         BOX_W            = 4,
    parameter int         BOX_H            = 4,
    parameter int         LANE_X_BASE      = 38,
    parameter int         LANE_X_PITCH     = 80,
    parameter logic [2:0] RESET_COLOUR     = WHITE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_PLAYERS-1:0] player_mask,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int RW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

    state_e state_q, state_d;
    logic [1:0] p_q, p_d;
    logic [2:0] b_q, b_d;
    logic [3:0] mask_q, mask_d;
    logic [7:0] bx_q, bx_d;
    logic [6:0] by_q, by_d;
    logic       fin_q, fin_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0]            mask_in;
    logic [NUM_PLAYERS-1:0] mask_sel;
    logic                  clr, en, last, adv;
    logic                  last_box, last_lane;
    logic [CW-1:0]         cx;
    logic [RW-1:0]         cy;
    logic [7:0]            bx_w;
    box_off_t              off;

`ifdef BOX_RESET_MASK_EN
    assign mask_sel = player_mask;
`else
    // Port stays for drop-in compatibility; every lane is forced on.
    assign mask_sel = player_mask | '1;
`endif
    assign mask_in = 4'(mask_sel);

    box_raster_counter #(
        .BOX_W(BOX_W),
        .BOX_H(BOX_H)
    ) u_raster (
        .clk   (clk),
        .rst   (reset),
        .clr_i (clr),
        .en_i  (en),
        .cx_o  (cx),
        .cy_o  (cy),
        .last_o(last)
    );

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        b_d     = b_q;
        mask_d  = mask_q;
        bx_d    = bx_q;
        by_d    = by_q;
        fin_d   = 1'b0;
        clr     = 1'b0;
        en      = 1'b0;
        adv     = 1'b0;
        plot_d  = 1'b0;
        x_d     = '0;
        y_d     = '0;

        off       = BOX_OFFSET[b_q];
        bx_w      = 8'(LANE_X_BASE) + 8'(p_q) * 8'(LANE_X_PITCH) + off.dx;
        last_box  = (b_q == 3'(BOXES_PER_PLAYER - 1));
        last_lane = (p_q == 2'(NUM_PLAYERS - 1));

        // The raster counter runs one pixel ahead of the output registers;
        // fin_q marks that the pixel on the outputs is the box's last.
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = mask_in;
                    p_d     = '0;
                    b_d     = '0;
                    clr     = 1'b1;
                    state_d = (mask_in == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (mask_q[p_q]) begin
                    bx_d    = bx_w;
                    by_d    = off.dy;
                    state_d = DRAW;
                    plot_d  = 1'b1;
                    en      = 1'b1;
                    fin_d   = last;
                end else begin
                    adv = 1'b1;
                end
            end
            DRAW: begin
                if (fin_q) begin
                    adv = 1'b1;
                end else begin
                    plot_d = 1'b1;
                    en     = 1'b1;
                    fin_d  = last;
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
            if (last_box) begin
                b_d     = '0;
                p_d     = p_q + 2'd1;
                state_d = last_lane ? DONE : LOAD;
            end else begin
                b_d     = b_q + 3'd1;
                state_d = LOAD;
            end
        end

        if (plot_d) begin
            x_d = bx_d + 8'(cx);
            y_d = by_d + 7'(cy);
        end
        colour_d = plot_d ? RESET_COLOUR : 3'd0;
        busy_d   = (state_d == LOAD) || (state_d == DRAW);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            p_q      <= '0;
            b_q      <= '0;
            mask_q   <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            fin_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            b_q      <= b_d;
            mask_q   <= mask_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            fin_q    <= fin_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
